// File: rtl/hwpe_tcdm_port_mux_pkg.sv
// rtl/hwpe_tcdm_port_mux_pkg.sv - shared types and constants for the TCDM port mux
package hwpe_tcdm_mux_package;

   localparam int MUX_MAX_PORTS           = 8;
   localparam int DEFAULT_MAX_OUTSTANDING = 4;

   typedef logic [$clog2(MUX_MAX_PORTS)-1:0] port_idx_t;

   // Cyclic successor of a port index within n_ports.
   function automatic port_idx_t next_port(input port_idx_t idx, input int n_ports);
      if (idx == port_idx_t'(n_ports - 1)) begin
         return '0;
      end
      return idx + port_idx_t'(1);
   endfunction

endpackage

// File: rtl/hwpe_tcdm_port_mux_if.sv
// rtl/hwpe_tcdm_port_mux_if.sv - bundle of N TCDM request/response channels
interface hwpe_tcdm_port_mux_if #(
   parameter int N          = 1,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [N-1:0]                   req;
   logic [N-1:0]                   gnt;
   logic [N-1:0][ADDR_WIDTH-1:0]   add;
   logic [N-1:0]                   wen;
   logic [N-1:0][DATA_WIDTH/8-1:0] be;
   logic [N-1:0][DATA_WIDTH-1:0]   data;
   logic [N-1:0][DATA_WIDTH-1:0]   r_data;
   logic [N-1:0]                   r_valid;

   modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
   modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/hwpe_tcdm_port_mux_id_fifo.sv
// rtl/hwpe_tcdm_port_mux_id_fifo.sv - in-order FIFO of issuing port indices
module hwpe_tcdm_mux_id_fifo
   import hwpe_tcdm_mux_package::*;
#(
   parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  port_idx_t              din,
   output port_idx_t              dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   port_idx_t     mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Storage is not reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH; count tracks occupancy including simultaneous push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/hwpe_tcdm_port_mux.sv
// rtl/hwpe_tcdm_port_mux.sv - round-robin merge of N TCDM masters onto one TCDM slave
module hwpe_tcdm_port_mux
   import hwpe_tcdm_mux_package::*;
#(
   parameter int N_PORTS         = 3,
   parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   hwpe_tcdm_port_mux_if.slave   in_port,
   hwpe_tcdm_port_mux_if.master  out_port,
   output logic                  err_unexp
);
   port_idx_t                          rr_ptr;
   port_idx_t                          winner;
   port_idx_t                          fifo_head;
   logic                               winner_valid;
   logic                               out_req;
   logic                               handshake;
   logic                               pop;
   logic                               fifo_full;
   logic                               fifo_empty;
   logic [$clog2(MAX_OUTSTANDING):0]   fifo_count;
   logic [ADDR_WIDTH-1:0]              sel_add;
   logic                               sel_wen;
   logic [DATA_WIDTH/8-1:0]            sel_be;
   logic [DATA_WIDTH-1:0]              sel_data;

   // Pick the first requester at or after rr_ptr: upper segment first, then wrap to port 0.
   always_comb begin
      winner_valid = 1'b0;
      winner       = '0;
      for (int j = 0; j < N_PORTS; j++) begin
         if (!winner_valid && in_port.req[j] && (port_idx_t'(j) >= rr_ptr)) begin
            winner_valid = 1'b1;
            winner       = port_idx_t'(j);
         end
      end
      for (int j = 0; j < N_PORTS; j++) begin
         if (!winner_valid && in_port.req[j]) begin
            winner_valid = 1'b1;
            winner       = port_idx_t'(j);
         end
      end
   end

   // A full ID FIFO blocks requests outright so out_r_valid never reaches out_req.
   assign out_req   = winner_valid & ~fifo_full & ~rst;
   assign handshake = out_req & out_port.gnt[0];
   assign pop       = out_port.r_valid[0] & ~fifo_empty & ~rst;

   // Forward the winner's request fields; zero when nobody requests.
   always_comb begin
      sel_add  = '0;
      sel_wen  = 1'b0;
      sel_be   = '0;
      sel_data = '0;
      for (int j = 0; j < N_PORTS; j++) begin
         if (winner_valid && (winner == port_idx_t'(j))) begin
            sel_add  = in_port.add[j];
            sel_wen  = in_port.wen[j];
            sel_be   = in_port.be[j];
            sel_data = in_port.data[j];
         end
      end
   end

   assign out_port.req[0]  = out_req;
   assign out_port.add[0]  = sel_add;
   assign out_port.wen[0]  = sel_wen;
   assign out_port.be[0]   = sel_be;
   assign out_port.data[0] = sel_data;

   // Grant goes back to the winner only; responses are steered to the oldest issuer.
   always_comb begin
      in_port.gnt     = '0;
      in_port.r_valid = '0;
      in_port.r_data  = '0;
      for (int j = 0; j < N_PORTS; j++) begin
         in_port.gnt[j]     = handshake && (winner == port_idx_t'(j));
         in_port.r_valid[j] = pop && (fifo_head == port_idx_t'(j));
         in_port.r_data[j]  = out_port.r_data[0];
      end
   end

   // Pointer advances past the winner only when a transaction is actually accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (handshake) begin
         rr_ptr <= next_port(winner, N_PORTS);
      end
   end

   // Sticky flag for a response that has no recorded issuer.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_unexp <= 1'b0;
      end else if (out_port.r_valid[0] && (fifo_count == '0)) begin
         err_unexp <= 1'b1;
      end
   end

   hwpe_tcdm_mux_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (handshake),
      .pop   (pop),
      .din   (winner),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_hwpe_tcdm_port_mux.sv
// tb/tb_hwpe_tcdm_port_mux.sv - scoreboard bench for hwpe_tcdm_port_mux
module tb_hwpe_tcdm_port_mux;
   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      int          port;
      logic [31:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst;
   logic err_unexp;

   int   tests = 0;
   int   fails = 0;
   int   exp_gnt[$];
   int   outst[$];
   rsp_t exp_rsp[$];

   hwpe_tcdm_port_mux_if #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) in_if ();
   hwpe_tcdm_port_mux_if #(.N(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) out_if ();

   hwpe_tcdm_port_mux #(
      .N_PORTS         (N),
      .MAX_OUTSTANDING (4),
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_port   (in_if),
      .out_port  (out_if),
      .err_unexp (err_unexp)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f_add(input int p);
      return 32'(p * 256);
   endfunction

   function automatic logic f_wen(input int p);
      return (p != 2);
   endfunction

   function automatic logic [3:0] f_be(input int p);
      case (p)
         0:       return 4'hF;
         1:       return 4'h3;
         default: return 4'hC;
      endcase
   endfunction

   function automatic logic [31:0] f_data(input int p);
      return 32'hD000_0000 + 32'(p);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input int p);
      exp_gnt.push_back(p);
      outst.push_back(p);
   endtask

   task automatic start_resp(input logic [31:0] d);
      rsp_t e;
      out_if.r_valid[0] = 1'b1;
      out_if.r_data[0]  = d;
      if (outst.size() > 0) begin
         e.port = outst.pop_front();
         e.data = d;
         exp_rsp.push_back(e);
      end
   endtask

   task automatic drain(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         start_resp(base + 32'(i));
         tick();
      end
      out_if.r_valid[0] = 1'b0;
   endtask

   // Monitor: checks every grant and response the DUT presents against the queues.
   initial begin : monitor
      int   p;
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_in_gnt", 64'(in_if.gnt), 64'd0);
            chk("rst_in_r_valid", 64'(in_if.r_valid), 64'd0);
            chk("rst_out_req", 64'(out_if.req), 64'd0);
         end else begin
            if (in_if.gnt != '0) begin
               if (exp_gnt.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_gnt: got %b expected none", in_if.gnt);
               end else begin
                  p = exp_gnt.pop_front();
                  chk("gnt_onehot", 64'(in_if.gnt), 64'd1 << p);
                  chk("out_add", 64'(out_if.add[0]), 64'(f_add(p)));
                  chk("out_wen", 64'(out_if.wen[0]), 64'(f_wen(p)));
                  chk("out_be", 64'(out_if.be[0]), 64'(f_be(p)));
                  chk("out_data", 64'(out_if.data[0]), 64'(f_data(p)));
               end
            end
            if (in_if.r_valid != '0) begin
               if (exp_rsp.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_r_valid: got %b expected none", in_if.r_valid);
               end else begin
                  e = exp_rsp.pop_front();
                  chk("rsp_valid", 64'(in_if.r_valid), 64'd1 << e.port);
                  chk("rsp_data", 64'(in_if.r_data[e.port]), 64'(e.data));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst = 1'b1;
      for (int p = 0; p < N; p++) begin
         in_if.add[p]  = f_add(p);
         in_if.wen[p]  = f_wen(p);
         in_if.be[p]   = f_be(p);
         in_if.data[p] = f_data(p);
      end
      in_if.req         = 3'b111;
      out_if.gnt[0]     = 1'b1;
      out_if.r_valid[0] = 1'b1;
      out_if.r_data[0]  = 32'h0;
      tick();
      tick();
      rst               = 1'b0;
      in_if.req         = 3'b000;
      out_if.r_valid[0] = 1'b0;
      @(negedge clk);
      chk("reset_err_unexp", 64'(err_unexp), 64'd0);
      chk("idle_out_req", 64'(out_if.req), 64'd0);
      chk("idle_out_add", 64'(out_if.add[0]), 64'd0);
      tick();

      // Single port read from port 1
      in_if.req = 3'b010;
      expect_grant(1);
      @(negedge clk);
      chk("t1_out_req", 64'(out_if.req), 64'd1);
      tick();
      in_if.req = 3'b000;
      start_resp(32'h0000_CAFE);
      @(negedge clk);
      chk("t1_rdata_port0", 64'(in_if.r_data[0]), 64'hCAFE);
      chk("t1_rdata_port2", 64'(in_if.r_data[2]), 64'hCAFE);
      tick();
      out_if.r_valid[0] = 1'b0;

      // Round robin with continuous responses (push+pop every cycle)
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_if.req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         expect_grant(k % 3);
         if (k > 0) start_resp(32'h1000 + 32'(k));
         tick();
      end
      in_if.req = 3'b000;
      start_resp(32'h1006);
      tick();
      out_if.r_valid[0] = 1'b0;

      // Backpressure: four outstanding fills the ID FIFO
      in_if.req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         expect_grant(k % 3);
         tick();
      end
      @(negedge clk);
      chk("t3_full_out_req", 64'(out_if.req), 64'd0);
      tick();
      start_resp(32'h3000);
      @(negedge clk);
      chk("t3_full_with_pop_out_req", 64'(out_if.req), 64'd0);
      tick();
      out_if.r_valid[0] = 1'b0;
      expect_grant(1);
      @(negedge clk);
      chk("t3_reopen_out_req", 64'(out_if.req), 64'd1);
      tick();
      in_if.req = 3'b000;
      drain(4, 32'h3100);

      // Stall: grant held low with ports 0 and 2 requesting
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_if.req     = 3'b101;
      out_if.gnt[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_stall_in_gnt", 64'(in_if.gnt), 64'd0);
         chk("t4_stall_out_add", 64'(out_if.add[0]), 64'(f_add(0)));
         tick();
      end
      out_if.gnt[0] = 1'b1;
      expect_grant(0);
      tick();
      expect_grant(2);
      tick();
      in_if.req = 3'b000;

      // Push and pop together at count 2, then prove count stayed 2
      in_if.req = 3'b010;
      expect_grant(1);
      start_resp(32'h5000);
      tick();
      out_if.r_valid[0] = 1'b0;
      in_if.req = 3'b111;
      expect_grant(2);
      tick();
      expect_grant(0);
      tick();
      @(negedge clk);
      chk("t5_count_held_full", 64'(out_if.req), 64'd0);
      tick();
      in_if.req = 3'b000;
      drain(4, 32'h5100);

      // Reset with three outstanding, then orphan responses
      in_if.req = 3'b111;
      expect_grant(1);
      tick();
      expect_grant(2);
      tick();
      expect_grant(0);
      tick();
      in_if.req = 3'b000;
      rst = 1'b1;
      outst.delete();
      tick();
      rst = 1'b0;
      start_resp(32'h6000);
      @(negedge clk);
      chk("t6_no_r_valid", 64'(in_if.r_valid), 64'd0);
      tick();
      out_if.r_valid[0] = 1'b0;
      @(negedge clk);
      chk("t6_err_set", 64'(err_unexp), 64'd1);
      tick();
      tick();
      @(negedge clk);
      chk("t6_err_sticky", 64'(err_unexp), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_err_cleared", 64'(err_unexp), 64'd0);
      tick();

      chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
      chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
